// File: rtl/add_round_key_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key_stage_if
// Description : Handshake bus for the AddRoundKey stage. One interface holds
//               both the upstream side (i_valid/o_ready plus the beat
//               payload) and the downstream side (o_valid/i_ready plus the
//               result). Names are seen from the stage.
//               Optional macro ARK_BYPASS_EN adds the i_bypass payload bit.
// Modports    : slave  - the stage itself
//               master - the surrounding datapath (or a testbench)
// Revision    : 1.0 - initial release
// ============================================================================
interface add_round_key_stage_if #(
  parameter int DATA_W = 128,
  parameter int RND_W  = 4
);

  // upstream side
  logic              i_valid;
  logic              o_ready;
  logic              i_start;
  logic [DATA_W-1:0] i_data;
  logic [DATA_W-1:0] i_round_key;
`ifdef ARK_BYPASS_EN
  logic              i_bypass;
`endif

  // downstream side
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [RND_W-1:0]  o_round;
  logic              o_last_round;

  modport slave (
`ifdef ARK_BYPASS_EN
    input  i_bypass,
`endif
    input  i_valid,
    input  i_start,
    input  i_data,
    input  i_round_key,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data,
    output o_round,
    output o_last_round
  );

  modport master (
`ifdef ARK_BYPASS_EN
    output i_bypass,
`endif
    output i_valid,
    output i_start,
    output i_data,
    output i_round_key,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data,
    input  o_round,
    input  o_last_round
  );

endinterface
`default_nettype wire

// File: rtl/add_round_key_stage.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key_stage
// Description : Registered AES AddRoundKey stage (state XOR round key) with a
//               valid/ready handshake backed by a 2-entry skid buffer, and a
//               round counter that tags each beat with its round index and
//               flags the final round.
//               Optional macro ARK_BYPASS_EN adds bus.i_bypass; a beat taken
//               with i_bypass=1 stores i_data unmodified.
// Ports       : clk   - system clock, rising edge
//               n_rst - asynchronous active-low reset
//               bus   - add_round_key_stage_if.slave
//                       upstream  : i_valid, o_ready, i_start, i_data,
//                                   i_round_key (, i_bypass)
//                       downstream: o_valid, i_ready, o_data, o_round,
//                                   o_last_round
// Revision    : 1.0 - initial release
// ============================================================================
module add_round_key_stage #(
  parameter int DATA_W     = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  add_round_key_stage_if.slave  bus
);

  // Elaboration-time parameter sanity checks
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("add_round_key_stage: DATA_W must be a multiple of 8");
  end
  if ((1 << RND_W) <= NUM_ROUNDS) begin : g_bad_rnd_w
    $error("add_round_key_stage: RND_W too narrow for NUM_ROUNDS");
  end

  localparam logic [RND_W-1:0] C_ROUND_ONE  = RND_W'(1);
  localparam logic [RND_W-1:0] C_ROUND_LAST = RND_W'(NUM_ROUNDS);

  // Buffer occupancy: the head entry is the output register, the second
  // entry is the skid slot.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  occ_t              r_state;
  occ_t              w_state_nxt;
  logic              r_ready;

  logic [DATA_W-1:0] r_head_data;
  logic [RND_W-1:0]  r_head_round;
  logic              r_head_last;
  logic [DATA_W-1:0] r_skid_data;
  logic [RND_W-1:0]  r_skid_round;
  logic              r_skid_last;

  // Round index of the most recently accepted beat (0 before any accept)
  logic [RND_W-1:0]  r_round_cnt;

  logic              w_accept;
  logic              w_drain;
  logic              w_load_head_new;
  logic              w_load_head_skid;
  logic              w_load_skid;
  logic [DATA_W-1:0] w_data_new;
  logic [RND_W-1:0]  w_round_new;
  logic              w_last_new;

  assign w_accept = bus.i_valid && r_ready;
  assign w_drain  = (r_state != ST_EMPTY) && bus.i_ready;

`ifdef ARK_BYPASS_EN
  assign w_data_new = bus.i_bypass ? bus.i_data : (bus.i_data ^ bus.i_round_key);
`else
  assign w_data_new = bus.i_data ^ bus.i_round_key;
`endif

  // A new block, or the beat after the final round, restarts at round 1.
  assign w_round_new = (bus.i_start || (r_round_cnt == C_ROUND_LAST)) ?
                       C_ROUND_ONE : (r_round_cnt + C_ROUND_ONE);
  assign w_last_new  = (w_round_new == C_ROUND_LAST);

  // --------------------------------------------------------------------------
  // Occupancy state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and buffer load controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_new  = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt     = ST_ONE;
          w_load_head_new = 1'b1;
        end
      end
      ST_ONE: begin
        case ({w_accept, w_drain})
          2'b11: w_load_head_new = 1'b1;     // pass-through, occupancy kept
          2'b10: begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end
          2'b01: w_state_nxt = ST_EMPTY;
          default: ;
        endcase
      end
      ST_FULL: begin
        // r_ready is low here, so no accept can coincide with this drain.
        if (w_drain) begin
          w_state_nxt      = ST_ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered ready: a function of the next occupancy only, so upstream
  // never sees a combinational path from downstream i_ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ready <= 1'b1;
    end else begin
      r_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // --------------------------------------------------------------------------
  // Round counter: advances on accept only
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_round_cnt <= '0;
    end else if (w_accept) begin
      r_round_cnt <= w_round_new;
    end
  end

  // --------------------------------------------------------------------------
  // Head (output) register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_head_data  <= '0;
      r_head_round <= '0;
      r_head_last  <= 1'b0;
    end else if (w_load_head_new) begin
      r_head_data  <= w_data_new;
      r_head_round <= w_round_new;
      r_head_last  <= w_last_new;
    end else if (w_load_head_skid) begin
      r_head_data  <= r_skid_data;
      r_head_round <= r_skid_round;
      r_head_last  <= r_skid_last;
    end
  end

  // --------------------------------------------------------------------------
  // Skid slot
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_skid_data  <= '0;
      r_skid_round <= '0;
      r_skid_last  <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_data  <= w_data_new;
      r_skid_round <= w_round_new;
      r_skid_last  <= w_last_new;
    end
  end

  assign bus.o_ready      = r_ready;
  assign bus.o_valid      = (r_state != ST_EMPTY);
  assign bus.o_data       = r_head_data;
  assign bus.o_round      = r_head_round;
  assign bus.o_last_round = r_head_last;

endmodule
`default_nettype wire

// File: tb/tb_add_round_key_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_round_key_stage
// Description : Self-checking bench for add_round_key_stage. A queue-based
//               reference model (stage contents as a FIFO of at most two
//               beats) predicts every output; table vectors and directed
//               sequences add fixed expected values.
//               Build with ARK_BYPASS_EN to cover the bypass port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_round_key_stage;

  localparam int DATA_W     = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int RND_W      = 4;

  logic clk;
  logic n_rst;

  add_round_key_stage_if #(.DATA_W(DATA_W), .RND_W(RND_W)) bus ();

  add_round_key_stage #(
    .DATA_W     (DATA_W),
    .NUM_ROUNDS (NUM_ROUNDS),
    .RND_W      (RND_W)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: beats held by the stage, oldest first
  logic [DATA_W-1:0] mq_data[$];
  int                mq_round[$];
  int                m_cnt;

  typedef struct {
    logic              start;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] exp_data;
    int                exp_round;
    logic              exp_last;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("o_valid", DATA_W'(bus.o_valid), DATA_W'(mq_data.size() > 0));
    check("o_ready", DATA_W'(bus.o_ready), DATA_W'(mq_data.size() < 2));
    if (mq_data.size() > 0) begin
      check("o_data", bus.o_data, mq_data[0]);
      check("o_round", DATA_W'(bus.o_round), DATA_W'(mq_round[0]));
      check("o_last_round", DATA_W'(bus.o_last_round),
            DATA_W'(mq_round[0] == NUM_ROUNDS));
    end
  endtask

  task automatic model_reset();
    mq_data.delete();
    mq_round.delete();
    m_cnt = 0;
  endtask

  // Called just after a falling edge: drives inputs, steps the model across
  // the rising edge, then checks at the following falling edge.
  task automatic cycle(input logic v, input logic s, input logic [DATA_W-1:0] d,
                       input logic [DATA_W-1:0] k, input logic b, input logic r);
    bit acc;
    bit drn;
    logic [DATA_W-1:0] beat;
    bus.i_valid     = v;
    bus.i_start     = s;
    bus.i_data      = d;
    bus.i_round_key = k;
    bus.i_ready     = r;
`ifdef ARK_BYPASS_EN
    bus.i_bypass    = b;
    beat            = b ? d : (d ^ k);
`else
    beat            = d ^ k;
    if (b) beat = d ^ k;   // bypass input has no effect without the feature
`endif
    acc = v && (mq_data.size() < 2);
    drn = (mq_data.size() > 0) && r;
    @(posedge clk);
    if (drn) begin
      void'(mq_data.pop_front());
      void'(mq_round.pop_front());
    end
    if (acc) begin
      m_cnt = (s || m_cnt == NUM_ROUNDS) ? 1 : m_cnt + 1;
      mq_data.push_back(beat);
      mq_round.push_back(m_cnt);
    end
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [DATA_W-1:0] d1, d2, d3, k1, k2, k3, bd;

  initial begin
    vecs[0] = '{1'b1, 128'h046681e5e0cb199a48f8d37a2806264c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'ha49c7ff2689f352b6b5bea43026a5049, 1, 1'b0};
    vecs[1] = '{1'b0, {16{8'hff}}, {16{8'h0f}}, {16{8'hf0}}, 2, 1'b0};
    vecs[2] = '{1'b0, 128'h0123456789abcdef0123456789abcdef,
                128'h0123456789abcdef0123456789abcdef, 128'h0, 3, 1'b0};
    vecs[3] = '{1'b0, 128'h0, 128'hdeadbeef00000000cafef00d12345678,
                128'hdeadbeef00000000cafef00d12345678, 4, 1'b0};
    vecs[4] = '{1'b1, 128'h00000000000000000000000000000001,
                128'h80000000000000000000000000000000,
                128'h80000000000000000000000000000001, 1, 1'b0};
    vecs[5] = '{1'b0, 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa,
                128'h55555555555555555555555555555555,
                128'hffffffffffffffffffffffffffffffff, 2, 1'b0};

    model_reset();
    n_rst           = 1'b0;
    bus.i_valid     = 1'b1;
    bus.i_start     = 1'b1;
    bus.i_data      = rnd128();
    bus.i_round_key = rnd128();
    bus.i_ready     = 1'b0;
`ifdef ARK_BYPASS_EN
    bus.i_bypass    = 1'b0;
`endif

    // Reset held with active inputs
    repeat (3) @(negedge clk);
    check("rst o_valid", DATA_W'(bus.o_valid), '0);
    check("rst o_data", bus.o_data, '0);
    check("rst o_round", DATA_W'(bus.o_round), '0);
    check("rst o_last_round", DATA_W'(bus.o_last_round), '0);
    check("rst o_ready", DATA_W'(bus.o_ready), DATA_W'(1));
    bus.i_valid = 1'b0;
    n_rst = 1'b1;
    cycle(1'b0, 1'b1, rnd128(), rnd128(), 1'b0, 1'b1);
    check("idle o_valid", DATA_W'(bus.o_valid), '0);

    // Table vectors at full throughput
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].start, vecs[i].data, vecs[i].key, 1'b0, 1'b1);
      check($sformatf("vec%0d o_data", i), bus.o_data, vecs[i].exp_data);
      check($sformatf("vec%0d o_round", i), DATA_W'(bus.o_round),
            DATA_W'(vecs[i].exp_round));
      check($sformatf("vec%0d o_last", i), DATA_W'(bus.o_last_round),
            DATA_W'(vecs[i].exp_last));
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

    // Backpressure: three pushes while downstream is stalled
    d1 = rnd128(); d2 = rnd128(); d3 = rnd128();
    k1 = rnd128(); k2 = rnd128(); k3 = rnd128();
    cycle(1'b1, 1'b1, d1, k1, 1'b0, 1'b0);
    check("bp one ready", DATA_W'(bus.o_ready), DATA_W'(1));
    cycle(1'b1, 1'b0, d2, k2, 1'b0, 1'b0);
    check("bp full ready", DATA_W'(bus.o_ready), '0);
    cycle(1'b1, 1'b0, d3, k3, 1'b0, 1'b0);
    check("bp hold data", bus.o_data, d1 ^ k1);
    cycle(1'b1, 1'b0, d3, k3, 1'b0, 1'b1);   // drains D1, D3 still refused
    check("bp out D2", bus.o_data, d2 ^ k2);
    check("bp out D2 round", DATA_W'(bus.o_round), DATA_W'(2));
    cycle(1'b1, 1'b0, d3, k3, 1'b0, 1'b1);   // drains D2, accepts D3
    check("bp out D3", bus.o_data, d3 ^ k3);
    check("bp out D3 round", DATA_W'(bus.o_round), DATA_W'(3));
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("bp drained", DATA_W'(bus.o_valid), '0);

    // Round wrap across eleven back-to-back accepts
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, (i == 0), rnd128(), rnd128(), 1'b0, 1'b1);
      check($sformatf("wrap%0d round", i), DATA_W'(bus.o_round),
            DATA_W'((i % 10) + 1));
      check($sformatf("wrap%0d last", i), DATA_W'(bus.o_last_round),
            DATA_W'(i == 9));
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

    // Start ignored on a non-accepted cycle
    cycle(1'b1, 1'b1, rnd128(), rnd128(), 1'b0, 1'b1);
    cycle(1'b0, 1'b1, rnd128(), rnd128(), 1'b0, 1'b1);
    cycle(1'b1, 1'b0, rnd128(), rnd128(), 1'b0, 1'b1);
    check("ign start round", DATA_W'(bus.o_round), DATA_W'(2));

    // Reset in the middle of a block with the buffer full
    cycle(1'b1, 1'b0, rnd128(), rnd128(), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, rnd128(), rnd128(), 1'b0, 1'b0);
    check("mid full ready", DATA_W'(bus.o_ready), '0);
    #2 n_rst = 1'b0;
    #1;
    check("mid rst o_valid", DATA_W'(bus.o_valid), '0);
    check("mid rst o_ready", DATA_W'(bus.o_ready), DATA_W'(1));
    check("mid rst o_round", DATA_W'(bus.o_round), '0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    check_model();
    cycle(1'b1, 1'b1, rnd128(), rnd128(), 1'b0, 1'b1);
    check("post rst round", DATA_W'(bus.o_round), DATA_W'(1));

`ifdef ARK_BYPASS_EN
    bd = 128'h00112233445566778899aabbccddeeff;
    cycle(1'b1, 1'b0, bd, rnd128(), 1'b1, 1'b1);
    check("bypass o_data", bus.o_data, bd);
`else
    bd = '0;
`endif
    cycle(1'b0, 1'b0, bd, '0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
            rnd128(), rnd128(), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
